// File: rtl/syncount_param.sv
// syncount_param: parametrised up/down counter with load, wrap/saturate, tc and ovf.
// Optional registered Gray output qg is enabled by defining SYNCOUNT_GRAY_EN.
module syncount_param #(
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH - 1,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
`ifdef SYNCOUNT_GRAY_EN
    output logic [WIDTH-1:0] qg,
`endif
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;

    assign w_at_max  = (r_q == MAXV);
    assign w_at_zero = (r_q == '0);
    assign w_tc      = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

    // Next count: load (clamped to MAX) beats count beats hold.
    always_comb begin
        w_next = r_q;
        if (load) begin
            w_next = (din > MAXV) ? MAXV : din;
        end else if (en) begin
            if (up) begin
                if (!w_at_max)
                    w_next = r_q + 1'b1;
                else if (!SAT)
                    w_next = '0;
            end else begin
                if (!w_at_zero)
                    w_next = r_q - 1'b1;
                else if (!SAT)
                    w_next = MAXV;
            end
        end
    end

    // Count and boundary-pulse registers; ovf is tc delayed by one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_next;
            r_ovf <= w_tc;
        end
    end

`ifdef SYNCOUNT_GRAY_EN
    logic [WIDTH-1:0] r_qg;

    // Gray copy computed from the next count so it tracks q on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_qg <= '0;
        else
            r_qg <= w_next ^ (w_next >> 1);
    end

    assign qg = r_qg;
`endif

    assign q   = r_q;
    assign tc  = w_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_syncount_param.sv
// tb_syncount_param: directed checks of wrap, saturate, load clamp and reset.
// Define SYNCOUNT_GRAY_EN to also check the Gray output.
module tb_syncount_param;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_en, a_up, a_load;
    logic [3:0] a_din, a_q;
    logic       a_tc, a_ovf;

    logic       b_en, b_up, b_load;
    logic [3:0] b_din, b_q;
    logic       b_tc, b_ovf;

    logic       g_en, g_up, g_load;
    logic [3:0] g_din, g_q;
    logic       g_tc, g_ovf;
`ifdef SYNCOUNT_GRAY_EN
    logic [3:0] a_qg, b_qg, g_qg;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    syncount_param #(.WIDTH(4), .MAX(9), .SAT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .up(a_up), .load(a_load),
        .din(a_din), .q(a_q),
`ifdef SYNCOUNT_GRAY_EN
        .qg(a_qg),
`endif
        .tc(a_tc), .ovf(a_ovf)
    );

    syncount_param #(.WIDTH(4), .MAX(9), .SAT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .up(b_up), .load(b_load),
        .din(b_din), .q(b_q),
`ifdef SYNCOUNT_GRAY_EN
        .qg(b_qg),
`endif
        .tc(b_tc), .ovf(b_ovf)
    );

    syncount_param #(.WIDTH(4), .MAX(15), .SAT(1'b0)) dut_g (
        .clk(clk), .rst(rst), .en(g_en), .up(g_up), .load(g_load),
        .din(g_din), .q(g_q),
`ifdef SYNCOUNT_GRAY_EN
        .qg(g_qg),
`endif
        .tc(g_tc), .ovf(g_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_q;
        logic [3:0] exp_g;
        logic [3:0] prev_g;

        rst = 1'b0;
        a_en = 0; a_up = 1; a_load = 0; a_din = 0;
        b_en = 0; b_up = 1; b_load = 0; b_din = 0;
        g_en = 0; g_up = 1; g_load = 0; g_din = 0;
        #1;
        chk("rst_q", 32'(a_q), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_b_q", 32'(b_q), 0);

        // release, count up to 5
        tick();
        rst  = 1'b1;
        a_en = 1'b1;
        repeat (5) tick();
        chk("cnt5", 32'(a_q), 5);

        // asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        chk("async_q", 32'(a_q), 0);
        chk("async_ovf", 32'(a_ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_q0", 32'(a_q), 0);
        tick();
        chk("rel_q1", 32'(a_q), 1);
        tick();
        chk("rel_q2", 32'(a_q), 2);

        // up wrap from 8
        a_load = 1; a_din = 4'd8;
        tick();
        chk("ld8", 32'(a_q), 8);
        a_load = 0;
        #1;
        chk("tc_at8", 32'(a_tc), 0);
        tick();
        chk("upw_q9", 32'(a_q), 9);
        chk("upw_ovf9", 32'(a_ovf), 0);
        chk("upw_tc9", 32'(a_tc), 1);
        tick();
        chk("upw_q0", 32'(a_q), 0);
        chk("upw_ovf0", 32'(a_ovf), 1);
        chk("upw_tc0", 32'(a_tc), 0);
        tick();
        chk("upw_q1", 32'(a_q), 1);
        chk("upw_ovf1", 32'(a_ovf), 0);

        // down wrap from 1
        a_up = 0;
        #1;
        chk("dnw_tc1", 32'(a_tc), 0);
        tick();
        chk("dnw_q0", 32'(a_q), 0);
        chk("dnw_ovf0", 32'(a_ovf), 0);
        chk("dnw_tc0", 32'(a_tc), 1);
        tick();
        chk("dnw_q9", 32'(a_q), 9);
        chk("dnw_ovf9", 32'(a_ovf), 1);
        tick();
        chk("dnw_q8", 32'(a_q), 8);
        chk("dnw_ovf8", 32'(a_ovf), 0);

        // load clamp and priority over count
        a_load = 1; a_din = 4'd3;
        tick();
        chk("ld3", 32'(a_q), 3);
        a_din = 4'd12; a_up = 1;
        #1;
        chk("ld_tc", 32'(a_tc), 0);
        tick();
        chk("clamp_q", 32'(a_q), 9);
        chk("clamp_ovf", 32'(a_ovf), 0);
        a_load = 0;
        #1;
        chk("tc_max_up", 32'(a_tc), 1);
        a_en = 0;
        #1;
        chk("tc_dis", 32'(a_tc), 0);
        tick();
        chk("hold_q", 32'(a_q), 9);
        chk("hold_ovf", 32'(a_ovf), 0);

        // saturate up from 8, en held 4 cycles
        b_load = 1; b_din = 4'd8;
        tick();
        chk("sat_ld8", 32'(b_q), 8);
        b_load = 0; b_en = 1; b_up = 1;
        tick();
        chk("sat_q_c1", 32'(b_q), 9);
        chk("sat_ovf_c1", 32'(b_ovf), 0);
        tick();
        chk("sat_q_c2", 32'(b_q), 9);
        chk("sat_ovf_c2", 32'(b_ovf), 1);
        tick();
        chk("sat_q_c3", 32'(b_q), 9);
        chk("sat_ovf_c3", 32'(b_ovf), 1);
        tick();
        chk("sat_q_c4", 32'(b_q), 9);
        chk("sat_ovf_c4", 32'(b_ovf), 1);

        // saturate down at 0
        b_load = 1; b_din = 4'd0;
        tick();
        chk("satd_ld0", 32'(b_q), 0);
        chk("satd_ld_ovf", 32'(b_ovf), 0);
        b_load = 0; b_up = 0;
        tick();
        chk("satd_q", 32'(b_q), 0);
        chk("satd_ovf", 32'(b_ovf), 1);
        b_en = 0;

        // full-range count 0..15 and wrap, with Gray check when present
        g_en = 1; g_up = 1;
        exp_q  = 4'd0;
        prev_g = 4'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_q = exp_q + 4'd1;
            exp_g = exp_q ^ (exp_q >> 1);
            chk($sformatf("full_q%0d", i), 32'(g_q), 32'(exp_q));
`ifdef SYNCOUNT_GRAY_EN
            chk($sformatf("gray%0d", i), 32'(g_qg), 32'(exp_g));
            chk($sformatf("gray_adj%0d", i),
                32'($countones(g_qg ^ prev_g)), 1);
            prev_g = g_qg;
`else
            prev_g = exp_g;
`endif
        end
        chk("full_wrap_ovf", 32'(g_ovf), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed unfinished expected finished");
        $fatal(1, "timeout");
    end

endmodule
